// File: rtl/max2_frame_sched_if.sv
// Sample/result handshake bundle for max2_frame_sched.
// m_count exists only when MAX2_FRAME_CNT_EN is defined.
interface max2_frame_sched_if #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16
);
    localparam int CW = $clog2(MAX_LEN + 1);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_max;
    logic [DATA_W-1:0] m_second;
    logic              m_has_second;
    logic              m_trunc;
`ifdef MAX2_FRAME_CNT_EN
    logic [CW-1:0]     m_count;
`endif

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_max, m_second,
        input  m_has_second, m_trunc
`ifdef MAX2_FRAME_CNT_EN
        , input m_count
`endif
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_max, m_second,
        output m_has_second, m_trunc
`ifdef MAX2_FRAME_CNT_EN
        , output m_count
`endif
    );
endinterface

// File: rtl/max2_frame_sched.sv
// Per-frame largest / strictly-second-largest tracker with result handshake.
// Define MAX2_FRAME_CNT_EN to expose the frame sample count on m_count.
module max2_frame_sched #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16
) (
    input logic clk,
    input logic reset,
    max2_frame_sched_if.slave bus
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LEN_C = CW'(MAX_LEN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] acc_max;
    logic [DATA_W-1:0] acc_sec;
    logic              acc_has;
    logic [CW-1:0]     cnt;

    logic [DATA_W-1:0] o_max;
    logic [DATA_W-1:0] o_sec;
    logic              o_has;
    logic              o_trunc;
    logic [CW-1:0]     o_cnt;

    logic              idle;
    logic              accept;
    logic              closing;
    logic              grow;
    logic              ins;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] nx_max;
    logic [DATA_W-1:0] nx_sec;
    logic              nx_has;
    logic [CW-1:0]     cnt_nx;

    assign d       = bus.s_data;
    assign idle    = (state == S_IDLE);
    assign accept  = bus.s_valid & bus.s_ready;
    assign cnt_nx  = idle ? CW'(1) : cnt + CW'(1);
    assign closing = bus.s_last | (cnt_nx == LEN_C);
    assign grow    = !idle && (d > acc_max);
    assign ins     = !idle && (acc_max > d)
                   && (!acc_has || d > acc_sec);

    // Duplicates of max or second fall through to default.
    always_comb begin
        nx_max = acc_max;
        nx_sec = acc_sec;
        nx_has = acc_has;
        unique case (1'b1)
            idle: begin
                nx_max = d;
                nx_sec = '0;
                nx_has = 1'b0;
            end
            grow: begin
                nx_sec = acc_max;
                nx_has = 1'b1;
                nx_max = d;
            end
            ins: begin
                nx_sec = d;
                nx_has = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            acc_max <= '0;
            acc_sec <= '0;
            acc_has <= 1'b0;
            cnt     <= '0;
            o_max   <= '0;
            o_sec   <= '0;
            o_has   <= 1'b0;
            o_trunc <= 1'b0;
            o_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc_max <= nx_max;
                        acc_sec <= nx_sec;
                        acc_has <= nx_has;
                        cnt     <= cnt_nx;
                        if (closing) begin
                            state   <= S_REPORT;
                            o_max   <= nx_max;
                            o_sec   <= nx_sec;
                            o_has   <= nx_has;
                            o_trunc <= ~bus.s_last;
                            o_cnt   <= cnt_nx;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_REPORT: begin
                    if (bus.m_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready      = reset & (state != S_REPORT);
    assign bus.m_valid      = (state == S_REPORT);
    assign bus.m_max        = o_max;
    assign bus.m_second     = o_sec;
    assign bus.m_has_second = o_has;
    assign bus.m_trunc      = o_trunc;
`ifdef MAX2_FRAME_CNT_EN
    assign bus.m_count      = o_cnt;
`else
    logic unused_cnt;
    assign unused_cnt = ^o_cnt;
`endif
endmodule

// File: tb/tb_max2_frame_sched.sv
// Directed bench for max2_frame_sched: instance a (MAX_LEN=16), b (MAX_LEN=4).
// Checks m_count as well when MAX2_FRAME_CNT_EN is defined.
module tb_max2_frame_sched;
    logic clk = 0;
    logic reset = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    max2_frame_sched_if #(.DATA_W(32), .MAX_LEN(16)) a ();
    max2_frame_sched_if #(.DATA_W(32), .MAX_LEN(4))  b ();

    max2_frame_sched #(.DATA_W(32), .MAX_LEN(16)) u_a (
        .clk(clk), .reset(reset), .bus(a.slave)
    );
    max2_frame_sched #(.DATA_W(32), .MAX_LEN(4)) u_b (
        .clk(clk), .reset(reset), .bus(b.slave)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_a(input logic [31:0] dv, input logic l);
        int n = 0;
        logic ok;
        a.s_valid = 1; a.s_data = dv; a.s_last = l;
        do begin
            ok = a.s_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        if (!ok) chk("send_a_timeout", 0, 1);
        a.s_valid = 0; a.s_last = 0;
    endtask

    task automatic send_b(input logic [31:0] dv, input logic l);
        int n = 0;
        logic ok;
        b.s_valid = 1; b.s_data = dv; b.s_last = l;
        do begin
            ok = b.s_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        if (!ok) chk("send_b_timeout", 0, 1);
        b.s_valid = 0; b.s_last = 0;
    endtask

    task automatic res_a(input string t, input logic [31:0] mx,
                         input logic [31:0] sc, input logic hs,
                         input logic tr, input int cn);
        chk({t, "_valid"},  a.m_valid, 1);
        chk({t, "_max"},    a.m_max, mx);
        chk({t, "_second"}, a.m_second, sc);
        chk({t, "_has"},    a.m_has_second, hs);
        chk({t, "_trunc"},  a.m_trunc, tr);
`ifdef MAX2_FRAME_CNT_EN
        chk({t, "_count"},  a.m_count, cn);
`else
        if (cn < 0) chk({t, "_cn"}, cn, 0);
`endif
    endtask

    task automatic res_b(input string t, input logic [31:0] mx,
                         input logic [31:0] sc, input logic tr);
        chk({t, "_valid"},  b.m_valid, 1);
        chk({t, "_max"},    b.m_max, mx);
        chk({t, "_second"}, b.m_second, sc);
        chk({t, "_trunc"},  b.m_trunc, tr);
    endtask

    initial begin
        a.s_valid = 0; a.s_data = 0; a.s_last = 0; a.m_ready = 1;
        b.s_valid = 0; b.s_data = 0; b.s_last = 0; b.m_ready = 1;
        #12;
        chk("rst_m_valid", a.m_valid, 0);
        chk("rst_s_ready", a.s_ready, 0);
        chk("rst_m_max",   a.m_max, 0);
        chk("rst_has",     a.m_has_second, 0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        chk("idle_s_ready", a.s_ready, 1);

        // Test 1
        send_a(5, 0); send_a(1, 0); send_a(10, 0);
        send_a(7, 0); send_a(10, 0);
        chk("t1_no_early_valid", a.m_valid, 0);
        send_a(3, 1);
        res_a("t1", 10, 7, 1, 0, 6);
        chk("t1_s_ready_rep", a.s_ready, 0);
        @(posedge clk); #1;
        chk("t1_valid_drop", a.m_valid, 0);
        chk("t1_hold_max", a.m_max, 10);
        chk("t1_s_ready_idle", a.s_ready, 1);

        // Test 2
        send_a(9, 1);
        res_a("t2", 9, 0, 0, 0, 1);
        @(posedge clk); #1;

        // Test 3
        send_a(4, 0); send_a(4, 0); send_a(4, 1);
        res_a("t3a", 4, 0, 0, 0, 3);
        @(posedge clk); #1;
        send_a(2, 0); send_a(8, 1);
        res_a("t3b", 8, 2, 1, 0, 2);
        @(posedge clk); #1;

        // Test 4: backpressure
        a.m_ready = 0;
        send_a(6, 0); send_a(11, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t4_s_ready_bp", a.s_ready, 0);
            chk("t4_hold_valid", a.m_valid, 1);
            chk("t4_hold_max", a.m_max, 11);
            chk("t4_hold_sec", a.m_second, 6);
        end
        a.m_ready = 1;
        a.s_valid = 1; a.s_data = 50; a.s_last = 1;
        @(posedge clk); #1;
        chk("t4_hs_valid", a.m_valid, 0);
        chk("t4_hs_s_ready", a.s_ready, 1);
        chk("t4_no_accept", a.m_max, 11);
        @(posedge clk); #1;
        a.s_valid = 0; a.s_last = 0;
        res_a("t4n", 50, 0, 0, 0, 1);
        @(posedge clk); #1;

        // Test 5: truncation on MAX_LEN=4
        send_b(1, 0); send_b(2, 0); send_b(3, 0); send_b(4, 0);
        res_b("t5a", 4, 3, 1);
        send_b(5, 0); send_b(6, 1);
        res_b("t5b", 6, 5, 0);
        send_b(7, 0); send_b(8, 0); send_b(9, 0); send_b(10, 1);
        res_b("t5c", 10, 9, 0);
        @(posedge clk); #1;

        // Test 6: reset mid-frame
        send_a(10, 0); send_a(20, 0);
        #2 reset = 0;
        #1;
        chk("t6_m_valid", a.m_valid, 0);
        chk("t6_s_ready", a.s_ready, 0);
        chk("t6_m_max", a.m_max, 0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        send_a(3, 0); send_a(1, 1);
        res_a("t6", 3, 1, 1, 0, 2);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
